// File: rtl/interp_fir_stream_if.sv
// Stream bundle for interp_fir_stream: sample input channel and interpolated output channel.
// master = producer/consumer side (testbench or upstream/downstream), slave = filter.
interface interp_fir_stream_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [1:0]        phase;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_last, phase, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, phase, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/interp_fir_stream.sv
// 4-tap line interpolation filter with edge replication, round/clip and full-stall backpressure.
// Optional macro INTERP_ROUND_EN: round half up before the >>>7; otherwise floor.
module interp_fir_stream #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = DATA_W + 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  interp_fir_stream_if.slave    bus
);
  localparam int STAGES = 2;
  localparam int COEF [4][4] = '{
    '{  0, 128,   0,   0},
    '{ -8, 108,  36,  -8},
    '{-12,  76,  76, -12},
    '{ -8,  36, 108,  -8}
  };
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << DATA_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

  state_t                   r_state;
  logic [3:0][DATA_W-1:0]   r_win;      // [0]=P0 .. [3]=P3 of the most recent issue
  logic [3:0][DATA_W-1:0]   w_win_nxt;
  logic [1:0]               r_pend;
  logic [1:0]               r_phase;
  logic [STAGES:1]          r_vld_pipe;
  logic [STAGES:1]          r_last_pipe;
  logic signed [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0]        r_out_data;
  logic                     w_stall, w_acc, w_issue, w_issue_last;
  logic signed [ACC_W-1:0]  w_prod [4];
  logic signed [ACC_W-1:0]  w_sum, w_res;
  logic [DATA_W-1:0]        w_clip;

  assign w_stall      = r_vld_pipe[STAGES] & ~bus.out_ready;
  assign bus.in_ready = rst_n & ~w_stall & (r_state != S_FLUSH);
  assign w_acc        = bus.in_valid & bus.in_ready;

  // Window shifts toward P0; new sample (or replicated s[N-1] in flush) enters at P3.
  always_comb begin
    w_win_nxt    = r_win;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    if (!w_stall) begin
      unique case (r_state)
        S_IDLE:  if (w_acc) w_win_nxt = {4{bus.in_data}};
        S_FILL:  if (w_acc) w_win_nxt = {bus.in_data, r_win[3:1]};
        S_RUN:   if (w_acc) begin
                   w_win_nxt = {bus.in_data, r_win[3:1]};
                   w_issue   = 1'b1;
                 end
        S_FLUSH: begin
                   w_win_nxt    = {r_win[3], r_win[3:1]};
                   w_issue      = 1'b1;
                   w_issue_last = (r_pend == 2'd1);
                 end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_win   <= '0;
      r_pend  <= '0;
      r_phase <= '0;
    end else begin
      r_win <= w_win_nxt;
      if (!w_stall) begin
        unique case (r_state)
          S_IDLE: if (w_acc) begin
            r_phase <= bus.phase;
            if (bus.in_last) begin
              r_state <= S_FLUSH;
              r_pend  <= 2'd1;
            end else begin
              r_state <= S_FILL;
            end
          end
          S_FILL: if (w_acc) begin
            if (bus.in_last) begin
              r_state <= S_FLUSH;
              r_pend  <= 2'd2;
            end else begin
              r_state <= S_RUN;
            end
          end
          S_RUN: if (w_acc && bus.in_last) begin
            r_state <= S_FLUSH;
            r_pend  <= 2'd2;
          end
          S_FLUSH: begin
            r_pend <= r_pend - 2'd1;
            if (r_pend == 2'd1) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Products are formed from the window being written this cycle, so stage 1 lands one edge after issue.
  for (genvar t = 0; t < 4; t++) begin : g_tap
    logic signed [ACC_W-1:0] w_smp, w_cf;
    assign w_smp     = $signed({{(ACC_W-DATA_W){1'b0}}, w_win_nxt[t]});
    assign w_cf      = ACC_W'(COEF[r_phase][t]);
    assign w_prod[t] = w_smp * w_cf;
  end

  assign w_sum = w_prod[0] + w_prod[1] + w_prod[2] + w_prod[3];

`ifdef INTERP_ROUND_EN
  assign w_res = (r_acc + ACC_W'(64)) >>> 7;
`else
  assign w_res = r_acc >>> 7;
`endif

  always_comb begin
    w_clip = w_res[DATA_W-1:0];
    if (w_res < 0)         w_clip = '0;
    else if (w_res > MAXV) w_clip = MAXV[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
    end else if (!w_stall) begin
      r_vld_pipe  <= {r_vld_pipe[1], w_issue};
      r_last_pipe <= {r_last_pipe[1], w_issue_last};
      r_acc       <= w_sum;
      r_out_data  <= w_clip;
    end
  end

  assign bus.out_valid = r_vld_pipe[STAGES];
  assign bus.out_last  = r_last_pipe[STAGES];
  assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_interp_fir_stream.sv
// Directed + randomized bench for interp_fir_stream against a line-level reference model.
module tb_interp_fir_stream;
  localparam int DW = 8;
  localparam int C [4][4] = '{
    '{  0, 128,   0,   0},
    '{ -8, 108,  36,  -8},
    '{-12,  76,  76, -12},
    '{ -8,  36, 108,  -8}
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  interp_fir_stream_if #(.DATA_W(DW)) bus();
  interp_fir_stream #(.DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int got_d[$], got_l[$], exp_d[$], exp_l[$];
  bit bp_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int floor_div128(input int a);
    if (a >= 0) return a / 128;
    return -((-a + 127) / 128);
  endfunction

  // Reference: output i draws s[i-1..i+2] with indices clamped to the line.
  function automatic void model(input int s[$], input int ph);
    int n, acc, res, idx;
    n = s.size();
    for (int i = 0; i < n; i++) begin
      acc = 0;
      for (int t = 0; t < 4; t++) begin
        idx = i - 1 + t;
        if (idx < 0) idx = 0;
        if (idx > n - 1) idx = n - 1;
        acc += C[ph][t] * s[idx];
      end
`ifdef INTERP_ROUND_EN
      res = floor_div128(acc + 64);
`else
      res = floor_div128(acc);
`endif
      if (res < 0) res = 0;
      if (res > 255) res = 255;
      exp_d.push_back(res);
      exp_l.push_back(i == n - 1 ? 1 : 0);
    end
  endfunction

  // Output collector plus hold / in_ready-during-stall checks.
  initial begin
    bit prev_stall = 1'b0;
    int prev_d = 0, prev_l = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(bus.out_valid), 1);
          chk("hold_data", 32'(bus.out_data), 32'(prev_d));
          chk("hold_last", 32'(bus.out_last), 32'(prev_l));
        end
        if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", 32'(bus.in_ready), 0);
        if (bus.out_valid && bus.out_ready) begin
          got_d.push_back(int'(bus.out_data));
          got_l.push_back(int'(bus.out_last));
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_d = int'(bus.out_data);
        prev_l = int'(bus.out_last);
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Entered and left at posedge+#1.
  task automatic send(input int d, input bit last, input int ph);
    bit hs;
    int cyc;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(d);
    bus.in_last  = last;
    bus.phase    = 2'(ph);
    cyc = 0;
    hs  = 1'b0;
    while (!hs && cyc < 1000) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!hs) begin
      n_tests++;
      n_fail++;
      $error("FAIL send_timeout observed=%0d expected=%0d", 0, 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_line(input int s[$], input int ph, input bit toggle);
    for (int i = 0; i < s.size(); i++)
      send(s[i], i == s.size() - 1, (toggle && i > 0) ? (ph ^ 3) : ph);
  endtask

  task automatic expect_outputs(input string tag);
    int cyc = 0;
    while (got_d.size() < exp_d.size() && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_count"}, 32'(got_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
      chk($sformatf("%s_l%0d", tag, i), 32'(got_l[i]), 32'(exp_l[i]));
    end
  endtask

  task automatic clear_q();
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  initial begin
    int s[$];
    int ph;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.phase    = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // constant line with latency check on s[2]
    send(100, 1'b0, 2);
    send(100, 1'b0, 2);
    send(100, 1'b0, 2);
    chk("lat_s2_cyc1", 32'(bus.out_valid), 0);
    send(100, 1'b1, 2);
    chk("lat_s2_cyc2", 32'(bus.out_valid), 1);
    exp_d = '{100, 100, 100, 100};
    exp_l = '{0, 0, 0, 1};
    expect_outputs("const");
    clear_q();

    // edge replication
    s = '{10, 20, 30, 40};
    send_line(s, 2, 1'b0);
`ifdef INTERP_ROUND_EN
    exp_d = '{14, 25, 36, 41};
`else
    exp_d = '{14, 25, 35, 40};
`endif
    exp_l = '{0, 0, 0, 1};
    expect_outputs("edge");
    clear_q();

    // clipping high then low
    s = '{0, 255, 255, 0};
    send_line(s, 2, 1'b0);
    model(s, 2);
    expect_outputs("clip_hi");
    if (got_d.size() > 1) chk("clip_hi_out1", 32'(got_d[1]), 255);
    clear_q();
    s = '{255, 0, 0, 255};
    send_line(s, 2, 1'b0);
    model(s, 2);
    expect_outputs("clip_lo");
    if (got_d.size() > 1) chk("clip_lo_out1", 32'(got_d[1]), 0);
    clear_q();

    // phase0 passthrough, N=1, and mid-line phase toggling
    s = '{7, 200, 33};
    send_line(s, 0, 1'b0);
    exp_d = '{7, 200, 33};
    exp_l = '{0, 0, 1};
    expect_outputs("ph0");
    clear_q();
    s = '{42};
    send_line(s, int'($urandom_range(0, 3)), 1'b0);
    exp_d = '{42};
    exp_l = '{1};
    expect_outputs("n1");
    clear_q();
    s = '{10, 80, 200, 30, 60};
    send_line(s, 1, 1'b1);
    model(s, 1);
    expect_outputs("toggle");
    clear_q();

    // random backpressure over long and short lines, lines sent back to back
    bp_en = 1'b1;
    for (int ln = 0; ln < 6; ln++) begin
      int n;
      n = (ln < 3) ? 64 : int'($urandom_range(1, 5));
      ph = int'($urandom_range(0, 3));
      s.delete();
      for (int k = 0; k < n; k++) s.push_back(int'($urandom_range(0, 255)));
      send_line(s, ph, ln[0]);
      model(s, ph);
    end
    expect_outputs("bp");
    clear_q();
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // reset in the middle of a line
    for (int k = 0; k < 5; k++) send(int'($urandom_range(0, 255)), 1'b0, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_out_last", 32'(bus.out_last), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 0);
    clear_q();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    s = '{50, 50};
    send_line(s, int'($urandom_range(0, 3)), 1'b0);
    exp_d = '{50, 50};
    exp_l = '{0, 1};
    expect_outputs("post_rst");
    clear_q();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/interp_fir_stream.md
# interp_fir_stream

Streaming 4-tap interpolation filter for the pixel datapath. Accepts unsigned samples one line at a time over a valid/ready stream and emits one interpolated sample per input sample. Each output is the fractional position between input i and i+1, with the phase selected per line from a fixed 4-entry coefficient table. It replicates samples at line edges, rounds and clips to the sample range, and is pipelined with full backpressure.

## Interface
- `DATA_W`, 8: sample width, unsigned.
- `ACC_W`, `DATA_W+10`: signed accumulator width; must be ≥ `DATA_W+10`.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block accepts sample this cycle.
- `in_data`  in  DATA_W  input sample.
- `in_last`  in  1  sample is last of its line.
- `phase`  in  2  coefficient set; sampled with first sample of line.
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  interpolated, clipped sample.
- `out_last`  out  1  marks last output of line.

## Operation
- Coefficient table, each set sums to 128:
  - phase0 {0,128,0,0}
  - phase1 {-8,108,36,-8}
  - phase2 {-12,76,76,-12}
  - phase3 {-8,36,108,-8}
- Output i uses P0=s[i-1], P1=s[i], P2=s[i+1], P3=s[i+2]. Indices <0 take s[0]; indices >N-1 take s[N-1].
- Line of N input samples produces exactly N outputs. `out_last` is set on output N-1 only.
- Phase is latched on accept of s[0]; changes to `phase` mid-line are ignored.
- Arithmetic:
  - Samples are zero-extended and multiplied by signed coefficients.
  - acc = sum of four products, ACC_W signed.
  - res = acc >>> 7 (see Configuration).
  - res<0 → 0; res>2^DATA_W-1 → 2^DATA_W-1; else res[DATA_W-1:0].
- FSM:
  - IDLE: accept s[0] → FILL; if in_last → FLUSH, 1 pending.
  - FILL: accept s[1] → RUN, no output; if in_last → FLUSH, 2 pending.
  - RUN: each accept of s[k] issues output k-2; in_last → FLUSH, 2 pending.
  - FLUSH: issues one pending output per unstalled cycle, replicating s[N-1]. `in_ready`=0. When the last output is issued → IDLE.
- Stall: when `out_valid && !out_ready`, the whole pipeline and FSM hold and `in_ready`=0.
- `in_valid` with `in_ready`=0 is a no-op; input must hold until accepted.

## Timing
- Reset (async, `rst_n` low): `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, FSM=IDLE, window cleared. `in_ready`=1 from the first cycle after deassertion.
- Reset mid-line discards the line and all in-flight outputs with no partial `out_last`.
- Pipeline:
  - Issue cycle: window update.
  - Stage 1: products and sum registered.
  - Stage 2: round and clip registered into `out_data`.
  - `out_valid` rises 2 cycles after the issuing handshake or flush cycle.
- Throughput: 1 sample/cycle sustained with `out_ready`=1.
- Line overhead: 2 flush cycles (1 when N=1), during which `in_ready`=0.
- A new line's s[0] may be accepted in the cycle after the final flush issue.
- `out_data`/`out_last` are stable while `out_valid && !out_ready`.

## Configuration
- `INTERP_ROUND_EN` defined: res = (acc + 64) >>> 7, round half up.
- `INTERP_ROUND_EN` undefined: res = acc >>> 7, floor. No other behaviour changes.

## Test plan
- Constant line: phase2, {100,100,100,100}, `out_ready`=1 → outputs {100,100,100,100}, `out_last` on the 4th output, first `out_valid` 2 cycles after s[2] is accepted.
- Edge replication: phase2, {10,20,30,40}, `INTERP_ROUND_EN` defined → {14,25,36,41}. Same line with the macro undefined → {14,25,35,40}.
- Clipping: phase2, {0,255,255,0} → output1=255. Line {255,0,0,255} → output1=0.
- Phase/short lines:
  - phase0, {7,200,33} → {7,200,33}.
  - N=1 line {42}, any phase → single output 42 with `out_last`=1.
  - `phase` toggled mid-line → no effect on that line.
- Backpressure: random `out_ready` (50%) over 64-sample lines → output stream matches the unstalled reference model, no drops or duplicates, held data stable, `in_ready`=0 whenever stalled.
- Reset mid-line: `rst_n` low after 5 samples of a 16-sample line → `out_valid`=0 immediately. Next line {50,50} → {50,50} with a correct `out_last`.
